// File: rtl/hsv_pixel_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : hsv_pixel_scheduler
// Purpose  : Round-robin sharing of one RGB-to-HSV converter among 2**IDW
//            pixel requesters, with a done/timeout wait and a tagged response.
// Revision : 1.0 - initial release
// ============================================================================
module hsv_pixel_scheduler #(
    parameter int IDW     = 2,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [(2**IDW)-1:0]     req_valid_i,
    output logic [(2**IDW)-1:0]     req_ready_o,
    input  logic [(2**IDW)*DW-1:0]  req_r_i,
    input  logic [(2**IDW)*DW-1:0]  req_g_i,
    input  logic [(2**IDW)*DW-1:0]  req_b_i,
    output logic                    conv_start_o,
    output logic [DW-1:0]           conv_r_o,
    output logic [DW-1:0]           conv_g_o,
    output logic [DW-1:0]           conv_b_o,
    input  logic                    conv_done_i,
    input  logic [DW-1:0]           conv_h_i,
    input  logic [DW-1:0]           conv_s_i,
    input  logic [DW-1:0]           conv_v_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [IDW-1:0]          rsp_id_o,
    output logic [DW-1:0]           rsp_h_o,
    output logic [DW-1:0]           rsp_s_o,
    output logic [DW-1:0]           rsp_v_o,
    output logic                    rsp_err_o,
    output logic [1:0]              state_o
);

    localparam int NREQ = 2**IDW;
    localparam int TW   = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t             state_q;
    logic [IDW-1:0]     ptr_q;
    logic [IDW-1:0]     id_q;
    logic [TW-1:0]      timer_q;
    logic               start_q;
    logic [DW-1:0]      conv_r_q, conv_g_q, conv_b_q;
    logic               rsp_valid_q;
    logic               rsp_err_q;
    logic [DW-1:0]      rsp_h_q, rsp_s_q, rsp_v_q;

    logic               grant_vld;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;

    // Search starts one past the last served requester; index wraps mod NREQ.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = ptr_q + IDW'(k);
            if (!grant_vld && req_valid_i[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign req_ready_o = (rst_ni && (state_q == S_IDLE) && grant_vld)
                       ? (NREQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            ptr_q       <= IDW'(NREQ - 1);
            id_q        <= '0;
            timer_q     <= '0;
            start_q     <= 1'b0;
            conv_r_q    <= '0;
            conv_g_q    <= '0;
            conv_b_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_h_q     <= '0;
            rsp_s_q     <= '0;
            rsp_v_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (grant_vld) begin
                        id_q     <= grant_idx;
                        conv_r_q <= req_r_i[int'(grant_idx)*DW +: DW];
                        conv_g_q <= req_g_i[int'(grant_idx)*DW +: DW];
                        conv_b_q <= req_b_i[int'(grant_idx)*DW +: DW];
                        start_q  <= 1'b1;
                        state_q  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    start_q <= 1'b0;
                    timer_q <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the final timer count still wins.
                    if (conv_done_i) begin
                        rsp_h_q     <= conv_h_i;
                        rsp_s_q     <= conv_s_i;
                        rsp_v_q     <= conv_v_i;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        rsp_h_q     <= '0;
                        rsp_s_q     <= '0;
                        rsp_v_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= S_RESP;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready_i) begin
                        ptr_q       <= id_q;
                        rsp_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign conv_start_o = start_q;
    assign conv_r_o     = conv_r_q;
    assign conv_g_o     = conv_g_q;
    assign conv_b_o     = conv_b_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_id_o     = id_q;
    assign rsp_h_o      = rsp_h_q;
    assign rsp_s_o      = rsp_s_q;
    assign rsp_v_o      = rsp_v_q;
    assign rsp_err_o    = rsp_err_q;
    assign state_o      = state_q;

endmodule
`default_nettype wire

// File: doc/hsv_pixel_scheduler.md
# hsv_pixel_scheduler

Shares one RGB-to-HSV converter among several pixel requesters. Round-robin arbitration picks one pending request, latches its R/G/B, pulses the converter's start, and waits for its done or a timeout. It then returns H/S/V tagged with the requester ID over a valid/ready response port. It sits between the pixel sources and the converter's start/ready control.

## Interface
Parameters:
- IDW, 2: requester ID width; NREQ = 2**IDW requesters (4).
- DW, 32: colour channel width.
- TIMEOUT, 15: maximum WAIT cycles before an error response (≥2).

Ports:
- Clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset; 0 = in reset.
- req_valid  in  NREQ  per-requester request pending.
- req_ready  out  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- req_R, req_G, req_B  in  NREQ*DW  flattened; requester i at [i*DW +: DW].
- conv_start  out  1  one-cycle start pulse to the converter.
- conv_R, conv_G, conv_B  out  DW  latched operands; held stable from ISSUE through WAIT.
- conv_done  in  1  converter result valid; sampled only in WAIT.
- conv_H, conv_S, conv_V  in  DW  converter results.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  IDW  requester ID of the response.
- rsp_H, rsp_S, rsp_V  out  DW  result; all zero when rsp_err = 1.
- rsp_err  out  1  converter timed out.
- State  out  2  debug: IDLE = 0, ISSUE = 1, WAIT = 2, RESP = 3.

## Operation
- **FSM states:** IDLE, ISSUE, WAIT, RESP.
- **IDLE:**
  - Grant rule: search i = ptr+1 … ptr+NREQ (mod NREQ); the first i with req_valid[i] wins.
  - req_ready is combinational in IDLE only: one-hot at the winner, zero otherwise and in every other state.
  - On grant: latch id and the winner's R/G/B into the conv_* registers, then go to ISSUE.
  - No req_valid: stay in IDLE.
- **ISSUE:** conv_start = 1 for exactly this cycle; clear the timer; go to WAIT.
- **WAIT:** the timer increments each cycle, starting at 0 on the first WAIT cycle.
  - conv_done = 1: capture conv_H/S/V into rsp_H/S/V, set rsp_err = 0, go to RESP.
  - Otherwise, timer == TIMEOUT-1: set rsp_H/S/V = 0, rsp_err = 1, go to RESP.
  - conv_done and timeout in the same cycle: done wins (err = 0).
- **RESP:** rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On the handshake cycle: ptr <= id, go to IDLE.
- conv_done in IDLE, ISSUE or RESP is ignored.
- A requester dropping req_valid before it is granted is legal; it simply loses the round.
- req_valid may change freely outside IDLE; it is not sampled there.

## Timing
- **Cycle numbering:** grant/transfer in cycle 0 (IDLE); conv_start in cycle 1; WAIT from cycle 2.
- **Response latency:** conv_done seen in cycle 2+j gives rsp_valid from cycle 3+j.
- **Timeout:** with no done, rsp_valid (err) appears in cycle TIMEOUT+2.
- **Throughput:** one transaction per ≥ j+4 cycles. The earliest next grant is the cycle after the rsp handshake; no overlap.
- **Reset values (reset = 0):** all outputs 0, State = IDLE, ptr = NREQ-1 (requester 0 has first priority), timer = 0, conv_* = 0.
- **Reset mid-operation:** the transaction is abandoned with no response. After release, operation restarts in IDLE with ptr = NREQ-1.
- **Timer:** width ≥ clog2(TIMEOUT); it never wraps, because the timeout exits WAIT first.

## Test plan
1. **Single request.** req_valid = 4'b0001, R = 255, G = 0, B = 0; stub asserts conv_done in cycle 4 with H = 0, S = 255, V = 255; rsp_ready = 1.
   -> req_ready[0] in cycle 0, conv_start in cycle 1 only, rsp_valid in cycle 5, rsp_id = 0, rsp_err = 0, H/S/V = 0/255/255.
2. **Fairness.** All four req_valid held high, stub done after 1 WAIT cycle.
   -> grant order 0, 1, 2, 3, 0; rsp_id sequence matches.
3. **Backpressure.** rsp_ready = 0 for 10 cycles after rsp_valid.
   -> rsp_* stable for all 10 cycles; req_ready = 0 throughout; State = 3 until the handshake.
4. **Timeout.** Stub never asserts conv_done, TIMEOUT = 15.
   -> rsp_valid in cycle 17, rsp_err = 1, rsp_H/S/V = 0.
5. **Simultaneous done and timeout.** conv_done asserted exactly on the last WAIT cycle (cycle 16).
   -> rsp_err = 0, results captured.
6. **Reset mid-WAIT.** Assert reset = 0 in cycle 3 of a transaction for requester 2.
   -> all outputs 0 immediately and no response; after release with all req_valid high, the first grant goes to requester 0.
